// File: rtl/rx_prbs9_ber_checker.sv
// PRBS9 (x^9+x^5+1) receive checker: slices samples, self-synchronizes, then counts bits/errors.
// Define PRBS_CHK_RELOCK_EN to drop lock when ERR_THR errors land in one ERR_WIN-bit window.
module rx_prbs9_ber_checker #(
    parameter int NBT_IN   = 8,
    parameter int NBT_CNT  = 32,
    parameter int LOCK_LEN = 16,
    parameter int ERR_WIN  = 64,
    parameter int ERR_THR  = 16
) (
    input  logic                     clk,
    input  logic                     i_reset,
    input  logic                     i_valid,
    input  logic signed [NBT_IN-1:0] i_sym,
    input  logic                     i_clr_cnt,
    output logic                     o_locked,
    output logic                     o_err,
    output logic [NBT_CNT-1:0]       o_bit_cnt,
    output logic [NBT_CNT-1:0]       o_err_cnt
);
    localparam int MW = $clog2(LOCK_LEN + 1);
    localparam logic [NBT_CNT-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t        state;
    logic [8:0]    s;
    logic [3:0]    fill_cnt;
    logic [MW-1:0] match_cnt;
    logic          rx_bit;
    logic          pred;
    logic          mism;
    logic          relock;
    logic          sym_unused;

    // Negative sample means a transmitted 1; only the sign matters.
    assign rx_bit     = i_sym[NBT_IN-1];
    assign sym_unused = ^i_sym[NBT_IN-2:0];
    assign pred       = s[8] ^ s[4];
    assign mism       = rx_bit ^ pred;

`ifdef PRBS_CHK_RELOCK_EN
    localparam int WW = $clog2(ERR_WIN);
    localparam int TW = $clog2(ERR_THR + 1);

    logic [WW-1:0] win_cnt;
    logic [TW-1:0] win_err;

    assign relock = mism && (win_err == TW'(ERR_THR - 1));

    // Window counters sit at zero outside LOCKED so each lock starts a fresh window.
    always_ff @(posedge clk) begin
        if (!i_reset) begin
            win_cnt <= '0;
            win_err <= '0;
        end else if (i_valid) begin
            if (state != LOCKED || relock || win_cnt == WW'(ERR_WIN - 1)) begin
                win_cnt <= '0;
                win_err <= '0;
            end else begin
                win_cnt <= win_cnt + WW'(1);
                win_err <= win_err + TW'(mism);
            end
        end
    end
`else
    assign relock = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            state     <= SEARCH;
            s         <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            o_locked  <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_err <= 1'b0;
            if (i_valid) begin
                case (state)
                    SEARCH: begin
                        s <= {s[7:0], rx_bit};
                        if (fill_cnt == 4'd8) begin
                            fill_cnt  <= '0;
                            match_cnt <= '0;
                            state     <= VERIFY;
                        end else begin
                            fill_cnt <= fill_cnt + 4'd1;
                        end
                    end
                    VERIFY: begin
                        // Received bits keep feeding s, so a bad bit flushes out after 9 valids.
                        s <= {s[7:0], rx_bit};
                        if (mism) begin
                            match_cnt <= '0;
                        end else if (match_cnt == MW'(LOCK_LEN - 1)) begin
                            match_cnt <= '0;
                            state     <= LOCKED;
                            o_locked  <= 1'b1;
                        end else begin
                            match_cnt <= match_cnt + MW'(1);
                        end
                    end
                    LOCKED: begin
                        s     <= {s[7:0], pred};
                        o_err <= mism;
                        if (relock) begin
                            state    <= SEARCH;
                            fill_cnt <= '0;
                            o_locked <= 1'b0;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

    // A saturated bit count freezes the error count so the ratio stays meaningful.
    always_ff @(posedge clk) begin
        if (!i_reset || i_clr_cnt) begin
            o_bit_cnt <= '0;
            o_err_cnt <= '0;
        end else if (i_valid && state == LOCKED && o_bit_cnt != CNT_MAX) begin
            o_bit_cnt <= o_bit_cnt + NBT_CNT'(1);
            if (mism && o_err_cnt != CNT_MAX)
                o_err_cnt <= o_err_cnt + NBT_CNT'(1);
        end
    end
endmodule

// File: tb/tb_rx_prbs9_ber_checker.sv
// Scoreboard bench for rx_prbs9_ber_checker: directed PRBS9 stimulus, expectations queued per clock.
// A second instance with 4-bit counters covers saturation behaviour.
module tb_rx_prbs9_ber_checker;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              valid = 1'b0;
    logic              clr = 1'b0;
    logic signed [7:0] sym = 8'sh00;
    logic              locked, err, locked2, err2;
    logic [31:0]       bc, ec;
    logic [3:0]        bc2, ec2;

    always #5 clk = ~clk;

    rx_prbs9_ber_checker dut (
        .clk(clk), .i_reset(rst_n), .i_valid(valid), .i_sym(sym), .i_clr_cnt(clr),
        .o_locked(locked), .o_err(err), .o_bit_cnt(bc), .o_err_cnt(ec)
    );

    rx_prbs9_ber_checker #(.NBT_CNT(4)) dut_sat (
        .clk(clk), .i_reset(rst_n), .i_valid(valid), .i_sym(sym), .i_clr_cnt(clr),
        .o_locked(locked2), .o_err(err2), .o_bit_cnt(bc2), .o_err_cnt(ec2)
    );

    typedef struct {
        int        cyc;
        string     name;
        bit        chk_st;
        bit        e_lock;
        bit        e_err;
        bit        chk_cnt;
        bit [31:0] e_bc;
        bit [31:0] e_ec;
        bit [3:0]  e_bc2;
        bit [3:0]  e_ec2;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Monitor: checks every queued expectation against the outputs after its clock edge.
    exp_t m;
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m = q.pop_front();
            if (m.cyc != cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: check for cycle %0d seen at cycle %0d", m.name, m.cyc, cyc);
                continue;
            end
            if (m.chk_st) begin
                cmp({m.name, ".o_locked"}, 32'(locked), 32'(m.e_lock));
                cmp({m.name, ".o_err"}, 32'(err), 32'(m.e_err));
            end
            if (m.chk_cnt) begin
                cmp({m.name, ".o_bit_cnt"}, bc, m.e_bc);
                cmp({m.name, ".o_err_cnt"}, ec, m.e_ec);
                cmp({m.name, ".sat_bit_cnt"}, 32'(bc2), 32'(m.e_bc2));
                cmp({m.name, ".sat_err_cnt"}, 32'(ec2), 32'(m.e_ec2));
            end
        end
    end

    logic [8:0] tx_s = 9'h1AA;
    bit         e_lock = 1'b0;
    int         to_lock = 25;
    int         drop_left = -1;

    task automatic push(string nm, bit cs, bit lk, bit er, bit cc,
                        bit [31:0] b, bit [31:0] e, bit [3:0] b2, bit [3:0] e2);
        exp_t r;
        r.cyc = cyc + 1; r.name = nm;
        r.chk_st = cs; r.e_lock = lk; r.e_err = er;
        r.chk_cnt = cc; r.e_bc = b; r.e_ec = e; r.e_bc2 = b2; r.e_ec2 = e2;
        q.push_back(r);
    endtask

    task automatic push_cnt(string nm, bit [31:0] b, bit [31:0] e, bit [3:0] b2, bit [3:0] e2);
        push(nm, 1'b0, 1'b0, 1'b0, 1'b1, b, e, b2, e2);
    endtask

    task automatic drive(bit v, logic signed [7:0] sy, bit c, bit r, string nm, bit lk, bit er);
        @(negedge clk);
        valid = v; sym = sy; clr = c; rst_n = ~r;
        push(nm, 1'b1, lk, er, 1'b0, 0, 0, 0, 0);
    endtask

    // One PRBS9 bit: three idle clocks then the valid; inv flips the transmitted sign.
    task automatic send_bit(bit inv, bit c = 1'b0);
        bit b, was;
        for (int k = 0; k < 3; k++) drive(1'b0, 8'($urandom), 1'b0, 1'b0, "idle", e_lock, 1'b0);
        b = tx_s[8] ^ tx_s[4];
        tx_s = {tx_s[7:0], b};
        was = e_lock;
        if (e_lock) begin
            if (inv && drop_left > 0) begin
                drop_left--;
                if (drop_left == 0) begin e_lock = 1'b0; to_lock = 25; end
            end
        end else if (inv) begin
            to_lock = 25;
        end else begin
            to_lock--;
            if (to_lock == 0) e_lock = 1'b1;
        end
        drive(1'b1, (b ^ inv) ? 8'shC0 : 8'sh40, c, 1'b0, "bit", e_lock, was && inv);
    endtask

    initial begin
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            valid = 1'($urandom); sym = 8'($urandom); clr = 1'($urandom); rst_n = 1'b0;
            push("reset", 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        end

        for (int i = 1; i <= 25; i++) send_bit(1'b0);
        push_cnt("at_lock", 0, 0, 0, 0);
        for (int i = 0; i < 1000; i++) send_bit(1'b0);
        push_cnt("run1000", 1000, 0, 15, 0);

        drive(1'b0, 8'sh00, 1'b1, 1'b0, "clr", 1'b1, 1'b0);
        push_cnt("clr", 0, 0, 0, 0);
        for (int i = 1; i <= 100; i++) send_bit(i == 100);
        push_cnt("err100", 100, 1, 15, 0);

        // Align the burst to the start of a 64-bit window (1152 locked bits so far).
        for (int i = 0; i < 52; i++) send_bit(1'b0);
        drive(1'b0, 8'sh00, 1'b1, 1'b0, "clr2", 1'b1, 1'b0);
        push_cnt("clr2", 0, 0, 0, 0);
`ifdef PRBS_CHK_RELOCK_EN
        drop_left = 16;
`endif
        for (int i = 0; i < 20; i++) send_bit(1'b1);
`ifdef PRBS_CHK_RELOCK_EN
        push_cnt("burst_drop", 16, 16, 15, 15);
        for (int i = 0; i < 25; i++) send_bit(1'b0);
        push_cnt("relock", 16, 16, 15, 15);
        drop_left = -1;
`else
        push_cnt("burst_hold", 20, 20, 15, 15);
`endif

        send_bit(1'b1, 1'b1);
        push_cnt("clr_err", 0, 0, 0, 0);

        e_lock = 1'b0;
        to_lock = 25;
        drive(1'b0, 8'sh00, 1'b0, 1'b1, "rst_lock", 1'b0, 1'b0);
        push_cnt("rst_lock", 0, 0, 0, 0);
        for (int i = 0; i < 25; i++) send_bit(1'b0);
        for (int i = 0; i < 10; i++) send_bit(1'b0);
        push_cnt("final", 10, 0, 10, 0);
        drive(1'b0, 8'sh00, 1'b0, 1'b0, "tail", e_lock, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rx_prbs9_ber_checker.md
RX_PRBS9_BER_CHECKER -- requirements
Module: rx_prbs9_ber_checker

Interface
REQ-001 SHALL have parameter NBT_IN, default 8, meaning total bits of the received sample (S(NBT_IN,NBT_IN-1)).
REQ-002 SHALL have parameter NBT_CNT, default 32, meaning width of the bit and error counters.
REQ-003 SHALL have parameter LOCK_LEN, default 16, meaning the number of consecutive correct predictions required to lock.
REQ-004 SHALL have parameter ERR_WIN, default 64, meaning the relock observation window in locked bits.
REQ-005 SHALL have parameter ERR_THR, default 16, meaning the number of errors within ERR_WIN that forces relock.
REQ-006 SHALL have port clk, input, 1 bit: system clock; all logic rising-edge.
REQ-007 SHALL have port i_reset, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port i_valid, input, 1 bit: one-cycle strobe marking a decision-instant sample (one per OVERSAMP clocks).
REQ-009 SHALL have port i_sym, input, NBT_IN bits, signed: received sample (AA-filter output, already phase-selected).
REQ-010 SHALL have port i_clr_cnt, input, 1 bit: synchronous clear of o_bit_cnt and o_err_cnt.
REQ-011 SHALL have port o_locked, output, 1 bit: checker synchronized to PRBS9.
REQ-012 SHALL have port o_err, output, 1 bit: one-cycle pulse per errored locked bit.
REQ-013 SHALL have port o_bit_cnt, output, NBT_CNT bits: locked bits compared.
REQ-014 SHALL have port o_err_cnt, output, NBT_CNT bits: locked bits in error.

Function
REQ-015 The slicer SHALL decide rx bit = MSB of i_sym (negative -> 1, zero or positive -> 0), matching the tx mapping 0->+1, 1->-1.
REQ-016 Polynomial: SHALL be x^9+x^5+1, same as tx_prbs9; predicted bit = s[8]^s[4], where the register shifts left and inserts the new bit at s[0].
REQ-017 FSM SHALL have three states: SEARCH, VERIFY, LOCKED; the state and all registers SHALL change only on clk edges where i_valid=1, except the clear/reset behaviour below.
REQ-018 SEARCH: SHALL shift rx bits into s; after 9 valid bits -> VERIFY.
REQ-019 VERIFY: SHALL compare the rx bit to the prediction and keep shifting rx bits into s (self-synchronizing); on a match, match_cnt++; on a mismatch, match_cnt=0 and the state stays VERIFY; on the LOCK_LEN-th consecutive match -> LOCKED.
REQ-020 LOCKED: s SHALL free-run on its own prediction (rx bits are not fed back); each valid increments o_bit_cnt; on a mismatch, o_err_cnt++ and o_err=1.
REQ-021 o_locked SHALL be 1 exactly while in LOCKED, asserting on the clock after the locking valid.
REQ-022 o_err SHALL be registered, high for one cycle, on the clock after the errored valid.
REQ-023 Counters SHALL saturate at 2^NBT_CNT-1 with no wrap-around; o_bit_cnt saturation SHALL freeze o_err_cnt too.
REQ-024 i_clr_cnt SHALL zero both counters on the next edge and take priority over a simultaneous valid, so that bit is not counted; o_err still pulses for it.
REQ-025 Counters SHALL hold their values on leaving LOCKED; they change only in LOCKED or on clear/reset.

Reset
REQ-026 i_reset=0 at a clk edge SHALL force SEARCH, s=0, match_cnt=0, window counters=0, o_locked=0, o_err=0, o_bit_cnt=0, o_err_cnt=0, overriding i_valid and i_clr_cnt, including mid-lock.

Configuration
REQ-027 With macro PRBS_CHK_RELOCK_EN defined, LOCKED SHALL count errors over consecutive ERR_WIN-bit windows; when the in-window error count reaches ERR_THR -> SEARCH on that edge (o_locked falls next clock, counters retained); window counters restart at each window end and on entry to LOCKED.
REQ-028 Without PRBS_CHK_RELOCK_EN, the window logic SHALL be absent and LOCKED SHALL be left only by reset.

Verification
REQ-029 The bench SHALL hold i_reset=0 for 10 clocks with random i_valid/i_sym -> all outputs 0 throughout.
REQ-030 The bench SHALL drive a clean PRBS9 (seed 9'h1AA) as +/-64 (8'sh40/8'shC0), valid every 4th clk -> o_locked=1 after valid #25; after 1000 further valids, o_bit_cnt=1000 and o_err_cnt=0.
REQ-031 When locked, the bench SHALL invert the sign of locked bit #100 -> exactly one o_err pulse, one clk after that valid, and o_err_cnt=1.
REQ-032 The bench SHALL invert 20 bits within one 64-bit window -> with the macro, o_locked falls at error #16 and relocks 25 clean valids later with o_err_cnt=16 retained; without the macro, o_locked stays 1 and o_err_cnt=20.
REQ-033 The bench SHALL assert i_clr_cnt on the same clk as an errored valid -> next clk, both counters are 0 and o_err=1.
REQ-034 The bench SHALL pulse i_reset=0 for 1 clk while locked -> next clk, o_locked=0 and counters are 0; relock occurs after 25 valids.
